// File: rtl/noc_rx_deframer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | noc_rx_deframer: byte-serial NOC command deframer with request FIFO.      |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module noc_rx_deframer #(
  parameter logic [3:0] MY_ID = 4'h1,
  parameter int         DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        noc_to_dev_ctl,
  input  logic [7:0]  noc_to_dev_data,
  output logic        req_valid,
  input  logic        req_ready,
  output logic        req_write,
  output logic [3:0]  req_src,
  output logic [31:0] req_addr,
  output logic [2:0]  req_len,
  output logic [63:0] req_data,
  output logic        err_pulse,
  output logic        drop_pulse,
  output logic [7:0]  err_count
);
  localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0] c_OP_RD  = 3'b001;
  localparam logic [2:0] c_OP_WR  = 3'b011;

  typedef enum logic [2:0] {S_IDLE, S_DEST, S_ADDR, S_DATA, S_SKIP} state_t;

  typedef struct packed {
    logic        write;
    logic [3:0]  src;
    logic [31:0] addr;
    logic [2:0]  len;
    logic [63:0] data;
  } entry_t;

  state_t      r_state;
  logic        r_write;
  logic [2:0]  r_len;
  logic [3:0]  r_src;
  logic [1:0]  r_acnt;
  logic [2:0]  r_dcnt;
  logic [31:0] r_addr;
  logic [63:0] r_data;
  logic        r_err;
  logic        r_drop;
  logic [7:0]  r_err_count;
  entry_t      r_mem [DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;

  entry_t      w_entry;
  entry_t      w_head;
  logic        w_push;
  logic        w_err;
  logic        w_pop;
  logic        w_full;
  logic        w_accept;
  logic        w_drop;

  // The entry is assembled with the final byte merged in, so it can be pushed
  // on the very cycle that byte arrives.
  always_comb begin
    w_push  = 1'b0;
    w_err   = 1'b0;
    w_entry = '{write: r_write, src: r_src, addr: r_addr,
                len: (r_write ? r_len : 3'd0), data: r_data};
    case (r_state)
      S_IDLE:                 w_err = ~noc_to_dev_ctl;
      S_DEST, S_ADDR, S_DATA: w_err = noc_to_dev_ctl;
      default:                w_err = 1'b0;
    endcase
    if (!noc_to_dev_ctl) begin
      if (r_state == S_ADDR && r_acnt == 2'd3 && !r_write) begin
        w_push             = 1'b1;
        w_entry.addr[31:24] = noc_to_dev_data;
      end
      if (r_state == S_DATA && r_dcnt == r_len) begin
        w_push                             = 1'b1;
        w_entry.data[{r_dcnt, 3'b000} +: 8] = noc_to_dev_data;
      end
    end
  end

  assign w_pop    = req_valid & req_ready;
  assign w_full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_accept = w_push & (~w_full | w_pop);
  assign w_drop   = w_push & ~w_accept;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_write     <= 1'b0;
      r_len       <= 3'd0;
      r_src       <= 4'd0;
      r_acnt      <= 2'd0;
      r_dcnt      <= 3'd0;
      r_addr      <= 32'd0;
      r_data      <= 64'd0;
      r_err       <= 1'b0;
      r_drop      <= 1'b0;
      r_err_count <= 8'd0;
    end else begin
      r_err  <= w_err;
      r_drop <= w_drop;
      if ((w_err || w_drop) && r_err_count != 8'hFF)
        r_err_count <= r_err_count + 8'd1;
      // Any ctl=1 byte restarts parsing, which also covers the abort case.
      if (noc_to_dev_ctl) begin
        r_data <= 64'd0;
        if (noc_to_dev_data == 8'h00) begin
          r_state <= S_IDLE;
        end else if (noc_to_dev_data[7:5] == c_OP_RD || noc_to_dev_data[7:5] == c_OP_WR) begin
          r_state <= S_DEST;
          r_write <= (noc_to_dev_data[7:5] == c_OP_WR);
          r_len   <= noc_to_dev_data[2:0];
        end else begin
          r_state <= S_SKIP;
        end
      end else begin
        case (r_state)
          S_DEST: begin
            if (noc_to_dev_data[7:4] != MY_ID) begin
              r_state <= S_SKIP;
            end else begin
              r_src   <= noc_to_dev_data[3:0];
              r_acnt  <= 2'd0;
              r_state <= S_ADDR;
            end
          end
          S_ADDR: begin
            r_addr[{r_acnt, 3'b000} +: 8] <= noc_to_dev_data;
            r_acnt <= r_acnt + 2'd1;
            if (r_acnt == 2'd3) begin
              r_dcnt  <= 3'd0;
              r_state <= r_write ? S_DATA : S_IDLE;
            end
          end
          S_DATA: begin
            r_data[{r_dcnt, 3'b000} +: 8] <= noc_to_dev_data;
            r_dcnt <= r_dcnt + 3'd1;
            if (r_dcnt == r_len)
              r_state <= S_IDLE;
          end
          default: r_state <= r_state;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else begin
      if (w_accept) begin
        r_mem[r_wptr[AW-1:0]] <= w_entry;
        r_wptr                <= r_wptr + 1'b1;
      end
      if (w_pop)
        r_rptr <= r_rptr + 1'b1;
    end
  end

  assign w_head     = r_mem[r_rptr[AW-1:0]];
  assign req_valid  = (r_wptr != r_rptr);
  assign req_write  = w_head.write;
  assign req_src    = w_head.src;
  assign req_addr   = w_head.addr;
  assign req_len    = w_head.len;
  assign req_data   = w_head.data;
  assign err_pulse  = r_err;
  assign drop_pulse = r_drop;
  assign err_count  = r_err_count;
endmodule
`default_nettype wire

// File: doc/noc_rx_deframer.md
Name: noc_rx_deframer

Overview:
- Sits directly downstream of the NOC-to-device byte link (noc_to_dev_ctl / noc_to_dev_data) on the device side.
- Parses byte-serial command packets addressed to this device into whole read/write requests.
- Queues requests in a small FIFO and presents them to the device core over a valid/ready handshake.
- The NOC side has no flow control, so the block must absorb bursts and report overruns and framing errors.

Parameters:
MY_ID, 4'h1, device id; packets with a different dest id are discarded.
DEPTH, 2, request FIFO depth in entries (power of two, ≥2).

Ports:
clk  in  1  single clock, rising edge.
reset  in  1  asynchronous, active-low reset.
noc_to_dev_ctl  in  1  1 = header/idle byte, 0 = payload byte.
noc_to_dev_data  in  8  link byte, sampled every clk.
req_valid  out  1  FIFO head holds a request.
req_ready  in  1  core accepts the head when req_valid=1.
req_write  out  1  1 = write, 0 = read.
req_src  out  4  source id of the request.
req_addr  out  32  byte address.
req_len  out  3  data byte count minus 1 (writes); 0 for reads.
req_data  out  64  write data, byte k in [8k+7:8k], unused bytes zero.
err_pulse  out  1  one-cycle framing-error strobe.
drop_pulse  out  1  one-cycle strobe: complete request lost, FIFO full.
err_count  out  8  saturating count of err_pulse and drop_pulse events.

Behaviour:
- Reset (reset=0, async): state=IDLE, FIFO empty, all outputs 0, err_count=0.
- Packet format:
  - Header (ctl=1): [7:5] opcode (3'b001 = read, 3'b011 = write, others reserved); [2:0] len; [4:3] ignored.
  - Then, all with ctl=0: dest/src byte ([7:4] dest, [3:0] src); 4 address bytes, LSB first; for writes only, len+1 data bytes.
- Idle byte: ctl=1 with data 8'h00. It is ignored in IDLE and SKIP.
- State machine, one byte per cycle:
  - IDLE:
    - nonzero header with valid opcode → DEST; capture opcode and len.
    - reserved opcode → SKIP, no error.
    - ctl=0 byte → err_pulse, stay in IDLE.
  - DEST: if dest≠MY_ID → SKIP (silent); else capture src, clear addr counter → ADDR.
  - ADDR: 2-bit counter; on the 4th byte: read → complete; write → DATA with byte counter cleared.
  - DATA: store byte at counter index; complete when counter==len.
  - SKIP: ctl=0 bytes consumed silently; a ctl=1 byte is handled exactly as in IDLE.
  - Abort: ctl=1 in DEST, ADDR or DATA abandons the partial packet and asserts err_pulse. The same byte is then processed as an IDLE-state header (idle byte → IDLE). No FIFO push occurs.
- Completion: on the final-byte cycle T the assembled entry is pushed. req_valid rises at T+1 when the FIFO was empty (1-cycle latency). The assembly data register is cleared at each new header.
- FIFO rules:
  - Pop on req_valid & req_ready.
  - Push is accepted if not full, or if full and a pop occurs in the same cycle.
  - Otherwise the entry is discarded, drop_pulse=1 and state → IDLE.
  - Outputs are the registered head entry and are stable while req_valid=1 and req_ready=0.
- err_count: +1 per err_pulse or drop_pulse; +1 only if both occur in the same cycle; saturates at 8'hFF.
- Simultaneous abort-header and push cannot occur (push happens only on a ctl=0 byte).

Test Plan:
- Read: hdr 8'h20, 8'h15 (dest 1, src 5), 8'h78,8'h56,8'h34,8'h12 → one cycle after the last byte: req_valid=1, req_write=0, req_src=5, req_addr=32'h12345678, req_len=0.
- Write 3 bytes: hdr 8'h62, 8'h1A, addr 8'h00,8'h10,0,0, data 8'hAA,8'hBB,8'hCC → req_write=1, req_len=2, req_addr=32'h1000, req_data=64'h0000_0000_00CC_BBAA.
- Dest mismatch: read packet with byte 8'h25, then a valid read to id 1 → only the second request appears; err_count=0.
- Abort: write header, dest byte, 2 address bytes, then header 8'h20 followed by a full read → err_pulse once, err_count=1, only the read is queued.
- Overrun, DEPTH=2, req_ready=0: three back-to-back reads → 2 queued, drop_pulse on the 3rd completion. Repeat with req_ready=1 during the 3rd completion → no drop.
- Async reset mid-DATA with req_valid=1 → outputs 0 immediately; the next clean packet is parsed correctly.
